// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter (mem_arbiter).
// Optional feature: ARB_ROUND_ROBIN_EN selects round-robin conflict resolution.
package mem_arb_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between the instruction-fetch and data requesters.
// With ARB_ROUND_ROBIN_EN a last-grant register alternates conflicts; otherwise D always wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
    input  logic clk_i,
    input  logic rst_ni,
    input  logic take_i,
`endif
    input  logic if_req_i,
    input  logic d_req_i,
    output gnt_e gnt_o,
    output logic any_o
);

    assign any_o = if_req_i | d_req_i;

`ifdef ARB_ROUND_ROBIN_EN
    gnt_e last_q, last_d;

    // Reset value GNT_I makes the data port win the first conflict.
    always_comb begin
        gnt_o = GNT_I;
        if (if_req_i && d_req_i) begin
            gnt_o = (last_q == GNT_I) ? GNT_D : GNT_I;
        end else if (d_req_i) begin
            gnt_o = GNT_D;
        end
        last_d = take_i ? gnt_o : last_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_q <= GNT_I;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign gnt_o = d_req_i ? GNT_D : GNT_I;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter onto a shared single-port memory with timeout and stall generation.
// Define ARB_ROUND_ROBIN_EN for round-robin conflicts; default build gives the data port priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_valid,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready,
    output logic                stall,
    output logic                busy,
    output logic                err,
    output logic [1:0]          dbg_state_o
);

    // Handshake: a requester raises req with its payload and holds both until its
    // one-cycle valid pulse; mem_req stays high with stable memory outputs until
    // mem_ready is seen on a clock edge (or the wait times out).

    localparam int STRB_W = DATA_W / 8;
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                if_valid_q, if_valid_d;
    logic                d_valid_q, d_valid_d;
    logic                err_q, err_d;
    gnt_e                gnt;
    logic                gnt_any;

`ifdef ARB_ROUND_ROBIN_EN
    logic take;
    assign take = (state_q == IDLE) && gnt_any;

    mem_arb_pick u_pick (
        .clk_i    (clk),
        .rst_ni   (rst),
        .take_i   (take),
        .if_req_i (if_req),
        .d_req_i  (d_req),
        .gnt_o    (gnt),
        .any_o    (gnt_any)
    );
`else
    mem_arb_pick u_pick (
        .if_req_i (if_req),
        .d_req_i  (d_req),
        .gnt_o    (gnt),
        .any_o    (gnt_any)
    );
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    cnt_d = '0;
                    if (gnt == GNT_D) begin
                        state_d = SERVE_D;
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                        wstrb_d = d_wstrb;
                    end else begin
                        state_d = SERVE_I;
                        addr_d  = if_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                        wstrb_d = '0;
                    end
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_ready) begin
                    state_d = IDLE;
                    if (state_q == SERVE_I) begin
                        if_rdata_d = mem_rdata;
                        if_valid_d = 1'b1;
                    end else begin
                        d_rdata_d = mem_rdata;
                        d_valid_d = 1'b1;
                    end
                end else if (cnt_q + 8'd1 == TMO) begin
                    // Give up: no valid, rdata registers keep their old contents.
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            cnt_q      <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
            err_q      <= err_d;
        end
    end

    assign mem_req     = (state_q != IDLE);
    assign busy        = (state_q != IDLE);
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_wstrb   = wstrb_q;
    assign if_rdata    = if_rdata_q;
    assign if_valid    = if_valid_q;
    assign d_rdata     = d_rdata_q;
    assign d_valid     = d_valid_q;
    assign err         = err_q;
    assign stall       = (if_req & ~if_valid_q) | (d_req & ~d_valid_q);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model; honours ARB_ROUND_ROBIN_EN like the design.
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [3:0]    d_wstrb = '0;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wstrb;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic          stall, busy, err;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall(stall), .busy(busy), .err(err), .dbg_state_o(dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference: one outstanding access, backing memory array.
    logic [31:0] mem_model [64];
    bit          m_busy = 0;
    bit          m_port = 0;
    int          m_wait = 0;
    int          m_delay = 0;
    logic [31:0] m_addr = '0;
    bit          m_we = 0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_wstrb = '0;
    bit          last_port = 0;
    bit          e_if_v = 0, e_d_v = 0, e_err = 0;
    logic [31:0] e_if_rd = '0, e_d_rd = '0;
    bit          d_rd_known = 1;
    int          force_delay = -1;

    // Observation scoreboard
    logic [0:0]  served_q[$];
    int          we_cnt = 0, iv_cnt = 0, dv_cnt = 0, err_cnt = 0;

    task automatic tick();
        if (m_busy) begin
            mem_ready = (m_wait >= m_delay);
            mem_rdata = m_we ? $urandom() : mem_model[m_addr[7:2]];
        end else begin
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom();
        end
        e_if_v = 0;
        e_d_v  = 0;
        e_err  = 0;
        if (!rst) begin
            m_busy = 0;
            e_if_rd = '0;
            e_d_rd = '0;
            d_rd_known = 1;
            last_port = 0;
        end else if (m_busy) begin
            if (mem_ready) begin
                m_busy = 0;
                if (m_port) begin
                    e_d_v = 1;
                    if (m_we) begin
                        for (int b = 0; b < 4; b++)
                            if (m_wstrb[b]) mem_model[m_addr[7:2]][8*b +: 8] = m_wdata[8*b +: 8];
                        d_rd_known = 0;
                    end else begin
                        e_d_rd = mem_rdata;
                        d_rd_known = 1;
                    end
                end else begin
                    e_if_v = 1;
                    e_if_rd = mem_rdata;
                end
            end else begin
                m_wait++;
                if (m_wait == TMO) begin
                    m_busy = 0;
                    e_err = 1;
                end
            end
        end else if (if_req || d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (if_req && d_req) m_port = (last_port == 0);
            else m_port = d_req;
            last_port = m_port;
`else
            m_port = d_req;
`endif
            m_busy  = 1;
            m_wait  = 0;
            m_addr  = m_port ? d_addr : if_addr;
            m_we    = m_port ? d_we : 1'b0;
            m_wdata = d_wdata;
            m_wstrb = m_port ? d_wstrb : 4'h0;
            m_delay = (force_delay >= 0) ? force_delay
                    : (($urandom_range(0, 9) == 0) ? 9 : int'($urandom_range(0, 3)));
        end
        @(posedge clk);
        @(negedge clk);
        check_eq("mem_req", mem_req, m_busy);
        check_eq("busy", busy, m_busy);
        if (m_busy) begin
            check_eq("mem_addr", mem_addr, m_addr);
            check_eq("mem_we", mem_we, m_we);
            check_eq("mem_wstrb", mem_wstrb, m_wstrb);
            if (m_we) check_eq("mem_wdata", mem_wdata, m_wdata);
        end
        check_eq("if_valid", if_valid, e_if_v);
        check_eq("d_valid", d_valid, e_d_v);
        check_eq("err", err, e_err);
        check_eq("if_rdata", if_rdata, e_if_rd);
        if (d_rd_known) check_eq("d_rdata", d_rdata, e_d_rd);
        check_eq("stall", stall, (if_req & ~e_if_v) | (d_req & ~e_d_v));
        if (mem_req && mem_we && mem_wdata == 32'hDEADBEEF) we_cnt++;
        if (if_valid) begin iv_cnt++; served_q.push_back(1'b0); if_req = 0; end
        if (d_valid)  begin dv_cnt++; served_q.push_back(1'b1); d_req = 0; end
        if (err) err_cnt++;
    endtask

    task automatic do_reset();
        rst = 0;
        if_req = 0;
        d_req = 0;
        tick();
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_wstrb", mem_wstrb, 0);
        check_eq("rst_stall", stall, 0);
        rst = 1;
    endtask

    task automatic clear_counts();
        we_cnt = 0; iv_cnt = 0; dv_cnt = 0; err_cnt = 0;
        served_q.delete();
    endtask

    task automatic wait_valid(input bit port, input int max, output int n);
        bit got = 0;
        n = 0;
        while (!got && n < max) begin
            tick();
            n++;
            if (port ? d_valid : if_valid) got = 1;
        end
        check_eq("wait_valid", got, 1);
    endtask

    task automatic drain();
        int n = 0;
        if_req = 0;
        d_req = 0;
        while (m_busy && n < 20) begin tick(); n++; end
        check_eq("drain_idle", busy, 0);
        tick();
    endtask

    initial begin
        int n;
        bit exp_g [4];
        for (int i = 0; i < 64; i++) mem_model[i] = $urandom();
        mem_model[16] = 32'h00500093;

        do_reset();
        tick();

        // Single IF read, memory ready on first cycle
        clear_counts();
        force_delay = 0;
        if_req = 1; if_addr = 32'h40;
        wait_valid(0, 10, n);
        check_eq("if_latency", n, 2);
        check_eq("if_rdata_026", if_rdata, 32'h00500093);

        // D write with three memory cycles
        clear_counts();
        force_delay = 2;
        d_req = 1; d_we = 1; d_addr = 32'h0; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
        wait_valid(1, 20, n);
        tick(); tick();
        check_eq("wr_held_cycles", we_cnt, 3);
        check_eq("wr_dvalid_cnt", dv_cnt, 1);
        check_eq("wr_ivalid_cnt", iv_cnt, 0);

        // Simultaneous held requests
        do_reset();
        clear_counts();
        force_delay = 1;
        if_req = 1; if_addr = 32'($urandom_range(0, 63)) << 2;
        d_req = 1; d_we = 0; d_addr = 32'($urandom_range(0, 63)) << 2;
        n = 0;
        while (served_q.size() < 4 && n < 60) begin
            tick();
            n++;
            if (!if_req) begin if_req = 1; if_addr = 32'($urandom_range(0, 63)) << 2; end
            if (!d_req) begin d_req = 1; d_addr = 32'($urandom_range(0, 63)) << 2; end
        end
        check_eq("conflict_count", served_q.size(), 4);
`ifdef ARB_ROUND_ROBIN_EN
        exp_g = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_g = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int k = 0; k < 4 && k < served_q.size(); k++)
            check_eq($sformatf("grant_%0d", k), served_q[k], exp_g[k]);
        drain();

        // Timeout with mem_ready held low
        clear_counts();
        force_delay = 100;
        d_req = 1; d_we = 0; d_addr = 32'h8;
        tick();
        check_eq("tmo_entry", mem_req, 1);
        n = 0;
        while (!err && n < 20) begin tick(); n++; end
        d_req = 0;
        check_eq("tmo_cycles", n, TMO);
        tick(); tick();
        check_eq("tmo_err_cnt", err_cnt, 1);
        check_eq("tmo_valid_cnt", iv_cnt + dv_cnt, 0);

        // Reset during SERVE_D
        clear_counts();
        d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = $urandom(); d_wstrb = 4'h3;
        tick(); tick();
        check_eq("pre_rst_busy", busy, 1);
        do_reset();
        tick();
        check_eq("rst_dvalid_cnt", dv_cnt, 0);
        force_delay = 0;
        d_req = 1; d_we = 0; d_addr = 32'h10;
        wait_valid(1, 10, n);
        check_eq("post_rst_latency", n, 2);

        // Randomized traffic
        force_delay = -1;
        for (int c = 0; c < 400; c++) begin
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1;
                if_addr = 32'($urandom_range(0, 63)) << 2;
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1;
                d_we = 1'($urandom_range(0, 1));
                d_addr = 32'($urandom_range(0, 63)) << 2;
                d_wdata = $urandom();
                d_wstrb = 4'($urandom_range(0, 15));
            end
            tick();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
